// File: rtl/decomp_prefetch_buffer_if.sv
// rtl/decomp_prefetch_buffer_if.sv - CPU fetch / decompressor bus bundle for the prefetch buffer
//
// Purpose: groups the CPU fetch port, the decompressor word stream, the redirect
// feedback and the occupancy report of decomp_prefetch_buffer.
// Modports:
//   slave  - the buffer: takes req/pc and in_* words; drives hit/instr, in_ready,
//            redirect/redirect_pc and count
//   master - the environment (CPU + decompressor): the mirror image
interface decomp_prefetch_buffer_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              req_cpu;
    logic [ADDR_W-1:0] pc_cpu;
    logic              hit_cpu;
    logic [WIDTH-1:0]  instr_cpu;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [WIDTH-1:0]  in_instr;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  req_cpu, pc_cpu, in_valid, in_pc, in_instr,
        output hit_cpu, instr_cpu, in_ready, redirect, redirect_pc, count
    );

    modport master (
        output req_cpu, pc_cpu, in_valid, in_pc, in_instr,
        input  hit_cpu, instr_cpu, in_ready, redirect, redirect_pc, count
    );
endinterface

// File: rtl/decomp_prefetch_buffer.sv
// rtl/decomp_prefetch_buffer.sv - PC-tagged prefetch FIFO between decompressor and CPU fetch port
//
// Purpose: queues decompressed words with their PC and serves CPU fetches from the
// FIFO head with one cycle of latency. A fetch PC that does not match the head (or,
// when empty, the next expected PC) flushes the queue and pulses redirect so the
// decompressor restarts at the requested PC.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - decomp_prefetch_buffer_if.slave (fetch port, word stream, redirect, count)
module decomp_prefetch_buffer #(
    parameter int                WIDTH    = 32,
    parameter int                ADDR_W   = 32,
    parameter int                PC_INC   = 4,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    decomp_prefetch_buffer_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    logic [ADDR_W-1:0] mem_pc    [DEPTH];
    logic [WIDTH-1:0]  mem_instr [DEPTH];

    state_t            state_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [ADDR_W-1:0] expect_pc_q;
    logic              hit_q;
    logic [WIDTH-1:0]  instr_q;
    logic              redirect_q;
    logic [ADDR_W-1:0] redirect_pc_q;

    logic              in_ready_w;
    logic              active;
    logic              empty;
    logic [ADDR_W-1:0] head_pc;
    logic              pc_eq_head;
    logic              pop;
    logic              mismatch;
    logic              push_en;

    always_comb begin
        in_ready_w = !redirect_q && (state_q != ST_BOOT) && (count_q < FULL_CNT);
        // Requests are only evaluated outside BOOT and outside the redirect pulse cycle.
        active     = !redirect_q && (state_q != ST_BOOT) && bus.req_cpu;
        empty      = (count_q == '0);
        head_pc    = mem_pc[head_q];
        pc_eq_head = (bus.pc_cpu == head_pc);
        pop        = active && !empty && pc_eq_head;
        mismatch   = active && (empty ? (bus.pc_cpu != expect_pc_q) : !pc_eq_head);
        // While refilling, words that are not the expected PC are consumed but discarded.
        push_en    = bus.in_valid && in_ready_w && !mismatch &&
                     ((state_q == ST_RUN) || (bus.in_pc == expect_pc_q));

        count_d = count_q;
        if (push_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_en) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_pc[tail_q]    <= bus.in_pc;
            mem_instr[tail_q] <= bus.in_instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            expect_pc_q   <= RESET_PC;
            hit_q         <= 1'b0;
            instr_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= RESET_PC;
        end else begin
            hit_q      <= 1'b0;
            redirect_q <= 1'b0;
            case (state_q)
                ST_BOOT: begin
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= RESET_PC;
                    state_q       <= ST_FILL;
                end
                default: begin
                    if (mismatch) begin
                        head_q        <= '0;
                        tail_q        <= '0;
                        count_q       <= '0;
                        expect_pc_q   <= bus.pc_cpu;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= bus.pc_cpu;
                        state_q       <= ST_FILL;
                    end else begin
                        if (pop) begin
                            hit_q   <= 1'b1;
                            instr_q <= mem_instr[head_q];
                            head_q  <= head_q + 1'b1;
                        end
                        if (push_en) begin
                            tail_q      <= tail_q + 1'b1;
                            expect_pc_q <= expect_pc_q + ADDR_W'(PC_INC);
                            state_q     <= ST_RUN;
                        end
                        count_q <= count_d;
                    end
                end
            endcase
        end
    end

    assign bus.hit_cpu     = hit_q;
    assign bus.instr_cpu   = instr_q;
    assign bus.in_ready    = in_ready_w;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_decomp_prefetch_buffer.sv
// tb/tb_decomp_prefetch_buffer.sv - directed self-checking bench for decomp_prefetch_buffer
module tb_decomp_prefetch_buffer;
    logic clk;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    decomp_prefetch_buffer_if #(.WIDTH(32), .ADDR_W(32), .DEPTH(4)) bus ();

    decomp_prefetch_buffer #(
        .WIDTH(32), .ADDR_W(32), .PC_INC(4), .DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = w;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] w,
                         input logic [2:0] cnt);
        bus.req_cpu = 1'b1;
        bus.pc_cpu  = pc;
        step();
        bus.req_cpu = 1'b0;
        chk({tag, "_hit"}, bus.hit_cpu, 1'b1);
        chk({tag, "_instr"}, bus.instr_cpu, w);
        chk({tag, "_count"}, bus.count, cnt);
    endtask

    initial begin
        reset        = 1'b0;
        bus.req_cpu  = 1'b0;
        bus.pc_cpu   = '0;
        bus.in_valid = 1'b0;
        bus.in_pc    = '0;
        bus.in_instr = '0;

        // 1: reset held three cycles, then one redirect pulse to PC 0
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hit", bus.hit_cpu, 1'b0);
            chk("rst_instr", bus.instr_cpu, 32'h0);
            chk("rst_redirect", bus.redirect, 1'b0);
            chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
            chk("rst_count", bus.count, 3'd0);
            chk("rst_in_ready", bus.in_ready, 1'b0);
        end
        reset = 1'b1;
        step();
        chk("boot_redirect", bus.redirect, 1'b1);
        chk("boot_redirect_pc", bus.redirect_pc, 32'h0);
        chk("boot_in_ready", bus.in_ready, 1'b0);
        step();
        chk("boot_redirect_drop", bus.redirect, 1'b0);
        chk("boot_in_ready_up", bus.in_ready, 1'b1);

        // 2: fill to full, then a hit at the head
        for (int i = 0; i < 4; i++) push(32'(4 * i), 32'hA0 + 32'(i));
        chk("full_count", bus.count, 3'd4);
        chk("full_in_ready", bus.in_ready, 1'b0);
        fetch("hit0", 32'h0, 32'hA0, 3'd3);
        chk("hit0_in_ready", bus.in_ready, 1'b1);
        step();
        chk("idle_hit", bus.hit_cpu, 1'b0);
        chk("idle_instr_hold", bus.instr_cpu, 32'hA0);

        // 3: drain, refill with 10..1C, then jump to 40
        fetch("hit4", 32'h4, 32'hA1, 3'd2);
        fetch("hit8", 32'h8, 32'hA2, 3'd1);
        fetch("hitC", 32'hC, 32'hA3, 3'd0);
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), 32'hA4 + 32'(i));
        chk("refill_count", bus.count, 3'd4);
        bus.req_cpu = 1'b1;
        bus.pc_cpu  = 32'h40;
        step();
        bus.req_cpu = 1'b0;
        chk("jmp_redirect", bus.redirect, 1'b1);
        chk("jmp_redirect_pc", bus.redirect_pc, 32'h40);
        chk("jmp_count", bus.count, 3'd0);
        chk("jmp_hit", bus.hit_cpu, 1'b0);
        step();
        chk("jmp_redirect_drop", bus.redirect, 1'b0);
        push(32'h20, 32'hBB);
        chk("stale_dropped", bus.count, 3'd0);
        push(32'h40, 32'hB0);
        chk("target_pushed", bus.count, 3'd1);
        push(32'h99, 32'hB1);
        chk("run_push_any", bus.count, 3'd2);
        fetch("hit40", 32'h40, 32'hB0, 3'd1);
        fetch("hit99", 32'h99, 32'hB1, 3'd0);

        // 4: simultaneous push and pop at count 2
        bus.req_cpu = 1'b1;
        bus.pc_cpu  = 32'h0;
        step();
        bus.req_cpu = 1'b0;
        chk("t4_redirect", bus.redirect, 1'b1);
        step();
        push(32'h0, 32'hC0);
        push(32'h4, 32'hC1);
        chk("t4_count2", bus.count, 3'd2);
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h8;
        bus.in_instr = 32'hC2;
        fetch("t4_pp", 32'h0, 32'hC0, 3'd2);
        bus.in_valid = 1'b0;
        fetch("t4_hit4", 32'h4, 32'hC1, 3'd1);
        fetch("t4_hit8", 32'h8, 32'hC2, 3'd0);

        // 5: asynchronous reset between edges
        for (int i = 0; i < 4; i++) push(32'hC + 32'(4 * i), 32'hD0 + 32'(i));
        fetch("t5_hit", 32'hC, 32'hD0, 3'd3);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_count", bus.count, 3'd0);
        chk("arst_hit", bus.hit_cpu, 1'b0);
        chk("arst_redirect_pc", bus.redirect_pc, 32'h0);
        chk("arst_instr", bus.instr_cpu, 32'h0);
        step();
        reset = 1'b1;
        step();
        chk("reboot_redirect", bus.redirect, 1'b1);
        step();

        // 6: expected PC wraps from FFFFFFFC to 0
        bus.req_cpu = 1'b1;
        bus.pc_cpu  = 32'hFFFF_FFFC;
        step();
        bus.req_cpu = 1'b0;
        chk("wrap_redirect_pc", bus.redirect_pc, 32'hFFFF_FFFC);
        step();
        push(32'hFFFF_FFFC, 32'hE0);
        chk("wrap_count", bus.count, 3'd1);
        fetch("wrap_hit", 32'hFFFF_FFFC, 32'hE0, 3'd0);
        bus.req_cpu = 1'b1;
        bus.pc_cpu  = 32'h0;
        step();
        chk("stall_redirect", bus.redirect, 1'b0);
        chk("stall_hit", bus.hit_cpu, 1'b0);
        step();
        chk("stall_redirect2", bus.redirect, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h0;
        bus.in_instr = 32'hE1;
        step();
        bus.in_valid = 1'b0;
        chk("stall_hit_pre", bus.hit_cpu, 1'b0);
        chk("stall_count", bus.count, 3'd1);
        step();
        bus.req_cpu = 1'b0;
        chk("stall_served_hit", bus.hit_cpu, 1'b1);
        chk("stall_served_instr", bus.instr_cpu, 32'hE1);
        chk("stall_served_count", bus.count, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
